// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter in front of a single
// byte-serial memory controller. LSU has priority with a starvation guard for IF.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_wr_i,
  input  logic [31:0] ls_addr_i,
  input  logic [1:0]  ls_len_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  output logic        mc_valid_o,
  output logic        mc_wr_o,
  output logic [31:0] mc_addr_o,
  output logic [1:0]  mc_len_o,
  output logic [31:0] mc_wdata_o,
  input  logic        mc_done_i,
  input  logic [31:0] mc_rdata_i
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, DRAIN} state_t;

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  state_t      state, state_n;
  logic [2:0]  starve_cnt, starve_n;
  logic        mc_valid_n, mc_wr_n, if_done_n, ls_done_n;
  logic [31:0] mc_addr_n, mc_wdata_n, if_rdata_n, ls_rdata_n;
  logic [1:0]  mc_len_n;
  logic        if_ok, if_win;

  always_comb begin
    state_n    = state;
    starve_n   = starve_cnt;
    mc_valid_n = mc_valid_o;
    mc_wr_n    = mc_wr_o;
    mc_addr_n  = mc_addr_o;
    mc_len_n   = mc_len_o;
    mc_wdata_n = mc_wdata_o;
    if_done_n  = 1'b0;
    ls_done_n  = 1'b0;
    if_rdata_n = if_rdata_o;
    ls_rdata_n = ls_rdata_o;
    // a flush in IDLE vetoes only the IF side; LSU may still be granted
    if_ok      = if_req_i && !if_flush_i;
    if_win     = if_ok && (!ls_req_i || starve_cnt == LIM);
    unique case (state)
      IDLE: begin
        if (if_win) begin
          state_n    = IF_BUSY;
          starve_n   = '0;
          mc_valid_n = 1'b1;
          mc_wr_n    = 1'b0;
          mc_addr_n  = if_addr_i;
          mc_len_n   = 2'b10;
        end else if (ls_req_i) begin
          state_n    = LS_BUSY;
          mc_valid_n = 1'b1;
          mc_wr_n    = ls_wr_i;
          mc_addr_n  = ls_addr_i;
          mc_len_n   = ls_len_i;
          mc_wdata_n = ls_wdata_i;
          if (!if_req_i)        starve_n = '0;
          else if (starve_cnt != LIM) starve_n = starve_cnt + 3'd1;
        end else if (!if_req_i) begin
          starve_n = '0;
        end
      end
      IF_BUSY: begin
        if (mc_done_i) begin
          state_n    = IDLE;
          mc_valid_n = 1'b0;
          if (!if_flush_i) begin
            if_done_n  = 1'b1;
            if_rdata_n = mc_rdata_i;
          end
        end else if (if_flush_i) begin
          state_n = DRAIN;
        end
      end
      LS_BUSY: begin
        if (mc_done_i) begin
          state_n    = IDLE;
          mc_valid_n = 1'b0;
          ls_done_n  = 1'b1;
          if (!mc_wr_o) ls_rdata_n = mc_rdata_i;
        end
      end
      DRAIN: begin
        // controller still owns the bus until it completes; data is dropped
        if (mc_done_i) begin
          state_n    = IDLE;
          mc_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mc_valid_o <= 1'b0;
      mc_wr_o    <= 1'b0;
      mc_addr_o  <= '0;
      mc_len_o   <= '0;
      mc_wdata_o <= '0;
      if_done_o  <= 1'b0;
      ls_done_o  <= 1'b0;
      if_rdata_o <= '0;
      ls_rdata_o <= '0;
    end else if (rdy) begin
      state      <= state_n;
      starve_cnt <= starve_n;
      mc_valid_o <= mc_valid_n;
      mc_wr_o    <= mc_wr_n;
      mc_addr_o  <= mc_addr_n;
      mc_len_o   <= mc_len_n;
      mc_wdata_o <= mc_wdata_n;
      if_done_o  <= if_done_n;
      ls_done_o  <= ls_done_n;
      if_rdata_o <= if_rdata_n;
      ls_rdata_o <= ls_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations, immediate assertions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_wr_i, ls_done_o;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic [1:0]  ls_len_i;
  logic        mc_valid_o, mc_wr_o, mc_done_i;
  logic [31:0] mc_addr_o, mc_wdata_o, mc_rdata_i;
  logic [1:0]  mc_len_o;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_wr_i(ls_wr_i), .ls_addr_i(ls_addr_i),
    .ls_len_i(ls_len_i), .ls_wdata_i(ls_wdata_i),
    .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
    .mc_valid_o(mc_valid_o), .mc_wr_o(mc_wr_o), .mc_addr_o(mc_addr_o),
    .mc_len_o(mc_len_o), .mc_wdata_o(mc_wdata_o),
    .mc_done_i(mc_done_i), .mc_rdata_i(mc_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    ls_req_i = 0; ls_wr_i = 0; ls_addr_i = 0; ls_len_i = 0; ls_wdata_i = 0;
    mc_done_i = 0; mc_rdata_i = 0;
    #2;
    chk("rst_valid", 32'(mc_valid_o), 0);
    chk("rst_addr", mc_addr_o, 0);
    chk("rst_if_done", 32'(if_done_o), 0);
    chk("rst_starve", 32'(dut.starve_cnt), 0);
    step(); step();
    rst = 1'b0;

    // IF-only fetch: command at cycle 1, done at cycle 6
    if_req_i = 1; if_addr_i = 32'h100;
    step();
    chk("if_valid_c1", 32'(mc_valid_o), 1);
    chk("if_addr", mc_addr_o, 32'h100);
    chk("if_wr", 32'(mc_wr_o), 0);
    chk("if_len", 32'(mc_len_o), 2);
    step(); step(); step(); step();
    chk("if_valid_c5", 32'(mc_valid_o), 1);
    mc_done_i = 1; mc_rdata_i = 32'h00A00093;
    step();
    chk("if_done_c6", 32'(if_done_o), 1);
    chk("if_rdata_c6", if_rdata_o, 32'h00A00093);
    chk("if_valid_off", 32'(mc_valid_o), 0);
    mc_done_i = 0; if_req_i = 0;
    step();
    chk("if_done_pulse", 32'(if_done_o), 0);

    // simultaneous: LSU store first, IF after ls_done
    if_req_i = 1; if_addr_i = 32'h200;
    ls_req_i = 1; ls_wr_i = 1; ls_len_i = 2'b00; ls_addr_i = 32'h30000; ls_wdata_i = 32'h41;
    step();
    chk("sim_wr", 32'(mc_wr_o), 1);
    chk("sim_len", 32'(mc_len_o), 0);
    chk("sim_addr", mc_addr_o, 32'h30000);
    chk("sim_wdata", mc_wdata_o, 32'h41);
    chk("sim_starve1", 32'(dut.starve_cnt), 1);
    step();
    mc_done_i = 1; mc_rdata_i = 32'hDEAD;
    step();
    chk("sim_ls_done", 32'(ls_done_o), 1);
    chk("sim_no_if_done", 32'(if_done_o), 0);
    chk("sim_store_rdata", ls_rdata_o, 0);
    mc_done_i = 0; ls_req_i = 0;
    step();
    chk("sim_if_valid", 32'(mc_valid_o), 1);
    chk("sim_if_addr", mc_addr_o, 32'h200);
    chk("sim_if_wr", 32'(mc_wr_o), 0);
    chk("sim_starve0", 32'(dut.starve_cnt), 0);
    mc_done_i = 1; mc_rdata_i = 32'h11111111;
    step();
    chk("sim_if_done", 32'(if_done_o), 1);
    chk("sim_if_rdata", if_rdata_o, 32'h11111111);
    mc_done_i = 0; if_req_i = 0;
    step();

    // starvation: 4 LSU loads, then IF
    if_req_i = 1; if_addr_i = 32'h400;
    ls_req_i = 1; ls_wr_i = 0; ls_len_i = 2'b10; ls_addr_i = 32'h500;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("stv_ls_addr", mc_addr_o, 32'h500);
      mc_done_i = 1; mc_rdata_i = 32'(k);
      step();
      chk("stv_ls_done", 32'(ls_done_o), 1);
      chk("stv_ls_rdata", ls_rdata_o, 32'(k));
      mc_done_i = 0;
    end
    step();
    chk("stv_if_addr", mc_addr_o, 32'h400);
    chk("stv_if_wr", 32'(mc_wr_o), 0);
    chk("stv_starve0", 32'(dut.starve_cnt), 0);
    ls_req_i = 0;
    mc_done_i = 1; mc_rdata_i = 32'hCAFE;
    step();
    chk("stv_if_done", 32'(if_done_o), 1);
    mc_done_i = 0; if_req_i = 0;
    step();

    // flush during IF_BUSY -> DRAIN, no if_done, LSU granted 2 cycles after done
    if_req_i = 1; if_addr_i = 32'h600;
    step();
    chk("fl_valid", 32'(mc_valid_o), 1);
    if_flush_i = 1; if_req_i = 0;
    ls_req_i = 1; ls_wr_i = 0; ls_len_i = 2'b01; ls_addr_i = 32'h700;
    step();
    chk("fl_drain", 32'(dut.state), 3);
    if_flush_i = 0;
    step();
    chk("fl_hold_addr", mc_addr_o, 32'h600);
    mc_done_i = 1; mc_rdata_i = 32'h5555;
    step();
    chk("fl_no_done", 32'(if_done_o), 0);
    chk("fl_rdata_kept", if_rdata_o, 32'hCAFE);
    chk("fl_valid_off", 32'(mc_valid_o), 0);
    mc_done_i = 0;
    step();
    chk("fl_ls_valid", 32'(mc_valid_o), 1);
    chk("fl_ls_addr", mc_addr_o, 32'h700);

    // rdy low for 3 cycles in LS_BUSY, then a held done pulse
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rdy_valid", 32'(mc_valid_o), 1);
      chk("rdy_len", 32'(mc_len_o), 1);
    end
    rdy = 1; mc_done_i = 1; mc_rdata_i = 32'h77;
    step();
    chk("rdy_ls_done", 32'(ls_done_o), 1);
    chk("rdy_ls_rdata", ls_rdata_o, 32'h77);
    rdy = 0; mc_done_i = 0; ls_req_i = 0;
    step(); step();
    chk("rdy_done_held", 32'(ls_done_o), 1);
    rdy = 1;
    step();
    chk("rdy_done_clr", 32'(ls_done_o), 0);

    // reset in LS_BUSY
    ls_req_i = 1; ls_wr_i = 1; ls_len_i = 2'b10; ls_addr_i = 32'h800; ls_wdata_i = 32'h99;
    step();
    chk("rs_valid", 32'(mc_valid_o), 1);
    step();
    #2 rst = 1;
    #1;
    chk("rs_async_valid", 32'(mc_valid_o), 0);
    chk("rs_async_wdata", mc_wdata_o, 0);
    chk("rs_async_ls_rdata", ls_rdata_o, 0);
    ls_req_i = 0; mc_done_i = 1;
    step();
    rst = 0; mc_done_i = 0;
    chk("rs_no_ls_done", 32'(ls_done_o), 0);
    if_req_i = 1; if_addr_i = 32'h900;
    step();
    chk("rs_if_addr", mc_addr_o, 32'h900);
    mc_done_i = 1; mc_rdata_i = 32'hABCD;
    step();
    chk("rs_if_done", 32'(if_done_o), 1);
    chk("rs_if_rdata", if_rdata_o, 32'hABCD);
    mc_done_i = 0; if_req_i = 0;
    step();

    // flush coincident with done suppresses if_done
    if_req_i = 1; if_addr_i = 32'hA00;
    step();
    mc_done_i = 1; if_flush_i = 1; mc_rdata_i = 32'h1234;
    step();
    chk("co_no_done", 32'(if_done_o), 0);
    chk("co_rdata_kept", if_rdata_o, 32'hABCD);
    chk("co_valid_off", 32'(mc_valid_o), 0);
    mc_done_i = 0;

    // flush in IDLE blocks the IF grant for that cycle
    step();
    chk("idf_blocked", 32'(mc_valid_o), 0);
    if_flush_i = 0;
    step();
    chk("idf_granted", 32'(mc_valid_o), 1);
    chk("idf_addr", mc_addr_o, 32'hA00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while IF waits.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rdy  in  1  global enable; when 0, all registers hold.
REQ-005 SHALL have ports if_req_i in 1 (fetch request, held until done or flush) and if_addr_i in 32 (fetch address, word read).
REQ-006 SHALL have ports if_flush_i in 1 (pc jump: cancel fetch), if_done_o out 1 (one-cycle pulse) and if_rdata_o out 32 (instruction, valid with if_done_o).
REQ-007 SHALL have ports ls_req_i in 1 (held until done), ls_wr_i in 1 (1 = store), ls_addr_i in 32, ls_len_i in 2 (00 byte, 01 half, 10/11 word) and ls_wdata_i in 32.
REQ-008 SHALL have ports ls_done_o out 1 (one-cycle pulse) and ls_rdata_o out 32 (load data, valid with ls_done_o).
REQ-009 SHALL have ports mc_valid_o out 1, mc_wr_o out 1, mc_addr_o out 32, mc_len_o out 2 and mc_wdata_o out 32 (downstream command to byte-serial memory controller).
REQ-010 SHALL have ports mc_done_i in 1 (one-cycle completion pulse) and mc_rdata_i in 32 (read data, valid with mc_done_i).

Function
REQ-011 SHALL implement states IDLE, IF_BUSY, LS_BUSY, DRAIN; all outputs registered.
REQ-012 In IDLE with any eligible request, SHALL grant: latch command into mc_* and set mc_valid_o next cycle (1-cycle request-to-command latency).
REQ-013 Priority SHALL be LSU over IF, except IF wins when starve_cnt == STARVE_LIMIT and if_req_i is high.
REQ-014 starve_cnt (3 bits, saturating at STARVE_LIMIT) SHALL increment on each LSU grant while if_req_i is high, and clear on any IF grant or whenever if_req_i is low in IDLE.
REQ-015 IF grant SHALL drive mc_wr_o=0, mc_len_o=10, mc_addr_o=if_addr_i; LSU grant SHALL pass ls_wr_i/ls_len_i/ls_addr_i/ls_wdata_i.
REQ-016 mc_valid_o and all mc_* fields SHALL stay stable from grant until the cycle after mc_done_i, then mc_valid_o=0.
REQ-017 In IF_BUSY on mc_done_i: if_rdata_o<=mc_rdata_i, if_done_o=1 for one cycle, go IDLE.
REQ-018 In LS_BUSY on mc_done_i: ls_rdata_o<=mc_rdata_i (loads only; stores leave it unchanged), ls_done_o=1 for one cycle, go IDLE.
REQ-019 if_flush_i in IF_BUSY without mc_done_i SHALL go DRAIN; DRAIN waits for mc_done_i, discards data (no if_done_o), then goes IDLE.
REQ-020 if_flush_i coincident with mc_done_i in IF_BUSY SHALL suppress if_done_o and go IDLE.
REQ-021 if_flush_i in IDLE SHALL block IF grant that cycle; LSU request may still be granted.
REQ-022 if_flush_i in LS_BUSY SHALL have no effect.
REQ-023 mc_done_i in IDLE SHALL be ignored.
REQ-024 A new grant SHALL NOT occur in the cycle a done pulse is emitted; earliest next mc_valid_o is 2 cycles after mc_done_i.
REQ-025 At most one done pulse per grant; if_done_o and ls_done_o never both high.

Reset
REQ-026 While rst=1: state IDLE, starve_cnt=0, mc_valid_o=0, mc_wr_o=0, mc_addr_o=0, mc_len_o=0, mc_wdata_o=0, if_done_o=0, ls_done_o=0, if_rdata_o=0, ls_rdata_o=0.
REQ-027 rst mid-transaction SHALL abandon it with no done pulse; downstream controller is reset by the same rst.

Verification
REQ-028 IF only: if_req_i=1, if_addr_i=0x100; mc_done_i at cycle 5 with 0x00A00093 -> mc_valid_o at cycle 1, if_done_o=1 and if_rdata_o=0x00A00093 at cycle 6.
REQ-029 Simultaneous requests: if_req_i and ls_req_i (store, len 00, addr 0x30000, data 0x41) -> LSU granted first (mc_wr_o=1, mc_len_o=00); IF granted after ls_done_o.
REQ-030 Starvation: ls_req_i held continuously with if_req_i held -> exactly 4 LSU grants, then IF grant, starve_cnt=0.
REQ-031 Flush: IF granted, if_flush_i pulse before mc_done_i -> DRAIN, no if_done_o; pending ls_req_i granted 2 cycles after mc_done_i.
REQ-032 rdy=0 for 3 cycles during LS_BUSY -> state, mc_* and pending done held; resumes unchanged when rdy=1.
REQ-033 rst asserted in LS_BUSY -> all outputs 0 asynchronously, no ls_done_o; after release, fresh if_req_i served normally.
